// File: rtl/breg_journal_pkg.sv
// Shared types for the register-file write journal: restore record, undo FSM states, mirror constant.
`ifndef BITNESS
`define BITNESS 16
`endif

package breg_journal_pkg;

    localparam int WORD_W = `BITNESS;

    // Registers below MIRROR_BASE have a mirror at wa+MIRROR_BASE that the file overwrites too
    localparam logic [3:0] MIRROR_BASE = 4'h8;

    typedef struct packed {
        logic [3:0]        wa;
        logic [WORD_W-1:0] old_lo;
        logic [WORD_W-1:0] old_hi;
    } rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_RESTORE_LO,
        ST_RESTORE_HI,
        ST_DONE
    } state_e;

    function automatic logic is_mirrored(input logic [3:0] wa);
        return wa < MIRROR_BASE;
    endfunction

endpackage

// File: rtl/journal_ring.sv
// Circular record store used as a stack: push at head, pop from head-1, oldest record lost on overflow.
module journal_ring
    import breg_journal_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rec_t          push_rec,
    input  logic          pop,
    output rec_t          top_rec,
    output logic [CW-1:0] depth,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] head_q;
    logic [CW-1:0] depth_q;
    logic          ovf_q;
    logic          full;

    assign full    = (depth_q == CW'(DEPTH));
    // Asynchronous read so the newest record is usable in the same cycle it is popped
    assign top_rec = mem[head_q - AW'(1)];
    assign depth   = depth_q;
    assign ovf     = ovf_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[head_q] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else if (push) begin
            head_q <= head_q + AW'(1);
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                depth_q <= depth_q + CW'(1);
            end
        end else if (pop && depth_q != '0) begin
            head_q  <= head_q - AW'(1);
            depth_q <= depth_q - CW'(1);
        end
    end

endmodule

// File: rtl/breg_journal.sv
// Write journal and undo engine: captures pre-write register values and replays them newest-first.
module breg_journal
    import breg_journal_pkg::*;
#(
    parameter int W     = WORD_W,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_w,
    input  logic [3:0]    cap_wa,
    input  logic [W-1:0]  cap_old,
    input  logic [W-1:0]  cap_old_hi,
    input  logic          undo_req,
    input  logic [CW-1:0] undo_cnt,
    output logic          undo_busy,
    output logic          undo_done,
    output logic          uw,
    output logic          uy,
    output logic [3:0]    uwa,
    output logic [W-1:0]  uwval,
    output logic [CW-1:0] depth,
    output logic          ovf,
    output logic          err
);

    state_e        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    rec_t          rec_q, rec_d;
    logic          uw_q, uw_d;
    logic [3:0]    uwa_q, uwa_d;
    logic [W-1:0]  uwval_q, uwval_d;
    logic          done_q, busy_q, err_q;

    logic          cap_acc;
    logic          ring_pop;
    rec_t          top_rec;
    rec_t          push_rec;
    logic [CW-1:0] ring_depth;
    logic [CW-1:0] depth_eff;

    assign cap_acc  = cap_w && (state_q == ST_IDLE);
    assign ring_pop = (state_q == ST_POP);
    assign push_rec = '{wa: cap_wa, old_lo: cap_old, old_hi: cap_old_hi};

    journal_ring #(.DEPTH(DEPTH), .CW(CW)) u_ring (
        .clk      (clk),
        .rst      (rst),
        .push     (cap_acc),
        .push_rec (push_rec),
        .pop      (ring_pop),
        .top_rec  (top_rec),
        .depth    (ring_depth),
        .ovf      (ovf)
    );

    // A capture in the request cycle is part of the undo, so count it before clamping
    assign depth_eff = ring_depth +
                       CW'(cap_acc && (ring_depth != CW'(DEPTH)));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rec_d   = rec_q;
        uw_d    = 1'b0;
        uwa_d   = '0;
        uwval_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (undo_req) begin
                    n_d     = (undo_cnt < depth_eff) ? undo_cnt : depth_eff;
                    state_d = (n_d == '0) ? ST_DONE : ST_POP;
                end
            end
            ST_POP: begin
                rec_d   = top_rec;
                n_d     = n_q - CW'(1);
                uw_d    = 1'b1;
                uwa_d   = top_rec.wa;
                uwval_d = top_rec.old_lo;
                state_d = ST_RESTORE_LO;
            end
            ST_RESTORE_LO: begin
                if (is_mirrored(rec_q.wa)) begin
                    uw_d    = 1'b1;
                    uwa_d   = rec_q.wa + MIRROR_BASE;
                    uwval_d = rec_q.old_hi;
                    state_d = ST_RESTORE_HI;
                end else begin
                    state_d = (n_q != '0) ? ST_POP : ST_DONE;
                end
            end
            ST_RESTORE_HI: state_d = (n_q != '0) ? ST_POP : ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            rec_q   <= '0;
            uw_q    <= 1'b0;
            uwa_q   <= '0;
            uwval_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rec_q   <= rec_d;
            uw_q    <= uw_d;
            uwa_q   <= uwa_d;
            uwval_q <= uwval_d;
            done_q  <= (state_q == ST_DONE);
            busy_q  <= (state_d == ST_POP) || (state_d == ST_RESTORE_LO) ||
                       (state_d == ST_RESTORE_HI);
            err_q   <= err_q | (cap_w && busy_q);
        end
    end

    assign undo_busy = busy_q;
    assign undo_done = done_q;
    assign uw        = uw_q;
    assign uy        = uw_q;
    assign uwa       = uwa_q;
    assign uwval     = uwval_q;
    assign depth     = ring_depth;
    assign err       = err_q;

endmodule

// File: tb/tb_breg_journal.sv
// Directed bench for breg_journal: expected undo writes are queued by stimulus and checked by a monitor.
module tb_breg_journal;
    import breg_journal_pkg::*;

    localparam int W     = WORD_W;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_w;
    logic [3:0]    cap_wa;
    logic [W-1:0]  cap_old, cap_old_hi;
    logic          undo_req;
    logic [CW-1:0] undo_cnt;
    logic          undo_busy, undo_done, uw, uy;
    logic [3:0]    uwa;
    logic [W-1:0]  uwval;
    logic [CW-1:0] depth;
    logic          ovf, err;

    typedef struct packed {
        logic [3:0]   wa;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_pulses = 0;

    always #5 clk = ~clk;

    breg_journal #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_w      (cap_w),
        .cap_wa     (cap_wa),
        .cap_old    (cap_old),
        .cap_old_hi (cap_old_hi),
        .undo_req   (undo_req),
        .undo_cnt   (undo_cnt),
        .undo_busy  (undo_busy),
        .undo_done  (undo_done),
        .uw         (uw),
        .uy         (uy),
        .uwa        (uwa),
        .uwval      (uwval),
        .depth      (depth),
        .ovf        (ovf),
        .err        (err)
    );

    // Scoreboard monitor: every uw pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (undo_done) done_pulses++;
        if (uw) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL uw_unexpected: got wa=%0d val=%0h, required no write", uwa, uwval);
            end else begin
                mon_e = exp_q.pop_front();
                if (uwa !== mon_e.wa || uwval !== mon_e.val || uy !== 1'b1) begin
                    n_err++;
                    $display("FAIL uw_write: got wa=%0d val=%0h uy=%0b, required wa=%0d val=%0h uy=1",
                             uwa, uwval, uy, mon_e.wa, mon_e.val);
                end else begin
                    $display("write wa=%0d val=%0h ok", uwa, uwval);
                end
            end
        end else if (uwa !== '0 || uwval !== '0 || uy !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_zero: got uwa=%0d uwval=%0h uy=%0b, required all 0", uwa, uwval, uy);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end else begin
            $display("check %s = %0h ok", nm, act);
        end
    endtask

    task automatic capture(input logic [3:0] wa, input logic [W-1:0] lo, input logic [W-1:0] hi);
        cap_w = 1'b1; cap_wa = wa; cap_old = lo; cap_old_hi = hi;
        @(posedge clk); #1;
        cap_w = 1'b0;
    endtask

    task automatic expect_wr(input logic [3:0] wa, input logic [W-1:0] val);
        exp_q.push_back('{wa: wa, val: val});
    endtask

    task automatic start_undo(input logic [CW-1:0] cnt);
        done_pulses = 0;
        undo_req = 1'b1; undo_cnt = cnt;
        @(posedge clk); #1;
        undo_req = 1'b0;
    endtask

    // Waits for undo_done; reports negedges until the first uw and until done
    task automatic wait_done(output int first_uw, output int done_lat, output int busy_cycles);
        int k;
        k = 0; first_uw = 0; done_lat = 0; busy_cycles = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (undo_busy) busy_cycles++;
            if (uw && first_uw == 0) first_uw = k;
            if (undo_done) begin
                done_lat = k;
                break;
            end
        end
        if (done_lat == 0) begin
            n_vec++; n_err++;
            $display("FAIL undo_timeout: got no undo_done in 200 cycles, required a pulse");
        end
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    int fu, dl, bc;

    initial begin
        rst = 1'b0; cap_w = 1'b0; cap_wa = '0; cap_old = '0; cap_old_hi = '0;
        undo_req = 1'b0; undo_cnt = '0;
        #1;
        check("rst_uw", 32'(uw), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_flags", {28'd0, ovf, err, undo_busy, undo_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Basic replay with mirrors
        capture(4'd2, W'(16'h11), W'(16'h22));
        capture(4'd9, W'(16'h33), W'(16'h00));
        capture(4'd5, W'(16'h44), W'(16'h55));
        check("depth_3", 32'(depth), 32'd3);
        expect_wr(4'd5, W'(16'h44)); expect_wr(4'd13, W'(16'h55));
        expect_wr(4'd9, W'(16'h33));
        expect_wr(4'd2, W'(16'h11)); expect_wr(4'd10, W'(16'h22));
        start_undo(CW'(3));
        wait_done(fu, dl, bc);
        check("t1_first_uw_lat", 32'(fu), 32'd2);
        check("t1_done_pulses", 32'(done_pulses), 32'd1);
        check("t1_depth", 32'(depth), 32'd0);
        check("t1_queue_left", 32'(exp_q.size()), 32'd0);

        // Empty journal
        start_undo(CW'(4));
        wait_done(fu, dl, bc);
        check("t2_done_lat", 32'(dl), 32'd2);
        check("t2_busy_cycles", 32'(bc), 32'd0);
        check("t2_done_pulses", 32'(done_pulses), 32'd1);

        // Overflow: 18 captures, oldest two lost
        for (int k = 0; k < DEPTH + 2; k++)
            capture(4'(8 + (k % 8)), W'(k + 1), W'(16'hFF));
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_depth_full", 32'(depth), 32'(DEPTH));
        for (int k = DEPTH + 1; k >= 2; k--)
            expect_wr(4'(8 + (k % 8)), W'(k + 1));
        start_undo(CW'(DEPTH));
        wait_done(fu, dl, bc);
        check("t3_depth_after", 32'(depth), 32'd0);
        check("t3_queue_left", 32'(exp_q.size()), 32'd0);

        // Capture attempted while busy
        capture(4'd10, W'(16'hA0), W'(16'h00));
        capture(4'd3, W'(16'h30), W'(16'h31));
        check("t4_err_before", 32'(err), 32'd0);
        expect_wr(4'd3, W'(16'h30)); expect_wr(4'd11, W'(16'h31));
        expect_wr(4'd10, W'(16'hA0));
        start_undo(CW'(2));
        @(posedge clk); #1;
        check("t4_in_restore_lo", {27'd0, uw, uwa}, {27'd0, 1'b1, 4'd3});
        capture(4'd15, W'(16'hEE), W'(16'hEF));
        wait_done(fu, dl, bc);
        check("t4_err", 32'(err), 32'd1);
        check("t4_depth", 32'(depth), 32'd0);
        check("t4_queue_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of RESTORE_HI
        capture(4'd4, W'(16'h40), W'(16'h41));
        expect_wr(4'd4, W'(16'h40));
        start_undo(CW'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_in_restore_hi", {27'd0, uw, uwa}, {27'd0, 1'b1, 4'd12});
        rst = 1'b0;
        #1;
        check("t5_rst_uw", 32'(uw), 32'd0);
        check("t5_rst_depth", 32'(depth), 32'd0);
        check("t5_rst_flags", {30'd0, ovf, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("t5_queue_left", 32'(exp_q.size()), 32'd0);
        start_undo(CW'(2));
        wait_done(fu, dl, bc);
        check("t5_post_done_lat", 32'(dl), 32'd2);
        check("t5_post_no_uw", 32'(fu), 32'd0);

        // Capture and undo request in the same cycle
        expect_wr(4'd12, W'(16'h77));
        cap_w = 1'b1; cap_wa = 4'd12; cap_old = W'(16'h77); cap_old_hi = '0;
        start_undo(CW'(1));
        cap_w = 1'b0;
        wait_done(fu, dl, bc);
        check("t6_done_pulses", 32'(done_pulses), 32'd1);
        check("t6_depth", 32'(depth), 32'd0);
        check("t6_queue_left", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
